// File: rtl/ocf_fsm.sv
// Z80 opcode-fetch (M1) sequencer: drives the M1 bus cycle at the captured PC,
// stretches it with WAIT_L, latches the opcode and then runs the refresh half
// with the 7-bit refresh counter on the address bus.
module ocf_fsm (
    input  logic        clk,
    input  logic        rst_L,
    input  logic [15:0] PC,
    input  logic        OCF_start,
    input  logic [7:0]  OCF_data_in,
    input  logic        INT_L,
    input  logic        NMI_L,
    input  logic        WAIT_L,
    output logic        OCF_done,
    output logic [7:0]  OCF_opcode_out,
    output logic        OCF_opcode_valid,
    output logic        OCF_M1_L,
    output logic        OCF_MREQ_L,
    output logic        OCF_RD_L,
    output logic [15:0] OCF_addr_out,
    output logic        OCF_RFSH_L
);

    typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, T4} state_t;

    state_t      state, state_d;
    logic [15:0] pc_q, pc_d;
    logic [6:0]  r_q, r_d;
    logic [7:0]  opcode_q, opcode_d;

    // Interrupt inputs are handled elsewhere in the CPU; they are only
    // present on this block for bus-interface symmetry.
    logic unused_int;
    assign unused_int = INT_L & NMI_L;

    // State, address latch, refresh counter and opcode register.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state    <= IDLE;
            pc_q     <= 16'h0000;
            r_q      <= 7'h00;
            opcode_q <= 8'h00;
        end else begin
            state    <= state_d;
            pc_q     <= pc_d;
            r_q      <= r_d;
            opcode_q <= opcode_d;
        end
    end

    // Next-state logic; the opcode byte is captured only on the edge that
    // leaves T2/TW with WAIT_L released, and R advances when T4 is left.
    always_comb begin
        state_d  = state;
        pc_d     = pc_q;
        r_d      = r_q;
        opcode_d = opcode_q;
        case (state)
            IDLE: begin
                if (OCF_start) begin
                    pc_d    = PC;
                    state_d = T1;
                end
            end
            T1: state_d = T2;
            T2, TW: begin
                if (WAIT_L) begin
                    opcode_d = OCF_data_in;
                    state_d  = T3;
                end else begin
                    state_d  = TW;
                end
            end
            T3: state_d = T4;
            T4: begin
                r_d = r_q + 7'd1;
                if (OCF_start) begin
                    pc_d    = PC;
                    state_d = T1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore output decode; the opcode comes straight from its register.
    always_comb begin
        OCF_M1_L         = 1'b1;
        OCF_MREQ_L       = 1'b1;
        OCF_RD_L         = 1'b1;
        OCF_RFSH_L       = 1'b1;
        OCF_addr_out     = 16'h0000;
        OCF_done         = 1'b0;
        OCF_opcode_valid = 1'b0;
        OCF_opcode_out   = opcode_q;
        case (state)
            T1, T2, TW: begin
                OCF_M1_L     = 1'b0;
                OCF_MREQ_L   = 1'b0;
                OCF_RD_L     = 1'b0;
                OCF_addr_out = pc_q;
            end
            T3: begin
                OCF_MREQ_L       = 1'b0;
                OCF_RFSH_L       = 1'b0;
                OCF_addr_out     = {9'b0, r_q};
                OCF_opcode_valid = 1'b1;
            end
            T4: begin
                OCF_RFSH_L       = 1'b0;
                OCF_addr_out     = {9'b0, r_q};
                OCF_opcode_valid = 1'b1;
                OCF_done         = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ocf_fsm.sv
// Bench for ocf_fsm: the driver issues fetches and pushes the expected
// transaction; a negedge monitor checks bus phases against the queue head.
module tb_ocf_fsm;

    logic        clk = 1'b0;
    logic        rst_L = 1'b0;
    logic [15:0] PC = 16'h0000;
    logic        OCF_start = 1'b0;
    logic [7:0]  OCF_data_in = 8'h00;
    logic        INT_L = 1'b1;
    logic        NMI_L = 1'b1;
    logic        WAIT_L = 1'b1;
    logic        OCF_done, OCF_opcode_valid, OCF_M1_L, OCF_MREQ_L, OCF_RD_L, OCF_RFSH_L;
    logic [7:0]  OCF_opcode_out;
    logic [15:0] OCF_addr_out;

    ocf_fsm dut (
        .clk(clk), .rst_L(rst_L), .PC(PC), .OCF_start(OCF_start),
        .OCF_data_in(OCF_data_in), .INT_L(INT_L), .NMI_L(NMI_L), .WAIT_L(WAIT_L),
        .OCF_done(OCF_done), .OCF_opcode_out(OCF_opcode_out),
        .OCF_opcode_valid(OCF_opcode_valid), .OCF_M1_L(OCF_M1_L),
        .OCF_MREQ_L(OCF_MREQ_L), .OCF_RD_L(OCF_RD_L),
        .OCF_addr_out(OCF_addr_out), .OCF_RFSH_L(OCF_RFSH_L)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  op;
        int          waits;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference view: R equals completed fetches mod 128, the opcode holds
    // the last completed byte, M1 lasts 2+waits cycles and refresh 2 cycles.
    int         done_cnt = 0;
    logic [7:0] last_op = 8'h00;
    int         m1cnt = 0;
    int         rfcnt = 0;

    always @(negedge clk) begin
        if (!rst_L) begin
            sb.delete();
            done_cnt = 0;
            last_op  = 8'h00;
            m1cnt    = 0;
            rfcnt    = 0;
        end else if (!OCF_M1_L) begin
            if (sb.size() == 0) begin
                check("m1_without_request", 1, 0);
            end else begin
                m1cnt++;
                check("m1_addr", OCF_addr_out, sb[0].pc);
                check("m1_strobes", {OCF_MREQ_L, OCF_RD_L, OCF_RFSH_L, OCF_opcode_valid, OCF_done}, 5'b00100);
                check("m1_opcode_hold", OCF_opcode_out, last_op);
            end
        end else if (!OCF_RFSH_L) begin
            if (sb.size() == 0) begin
                check("rfsh_without_request", 1, 0);
            end else begin
                rfcnt++;
                check("rfsh_addr", OCF_addr_out, 16'(done_cnt % 128));
                check("opcode", OCF_opcode_out, sb[0].op);
                check("rfsh_strobes", {OCF_M1_L, OCF_RD_L, OCF_opcode_valid}, 3'b111);
                if (OCF_done) begin
                    check("t4_mreq", OCF_MREQ_L, 1'b1);
                    check("m1_cycles", m1cnt, 2 + sb[0].waits);
                    check("rfsh_cycles", rfcnt, 2);
                    last_op = sb[0].op;
                    void'(sb.pop_front());
                    done_cnt++;
                    m1cnt = 0;
                    rfcnt = 0;
                end else begin
                    check("t3_mreq", OCF_MREQ_L, 1'b0);
                end
            end
        end else begin
            check("idle_strobes", {OCF_MREQ_L, OCF_RD_L, OCF_opcode_valid, OCF_done}, 4'b1100);
            check("idle_addr", OCF_addr_out, 16'h0000);
            check("idle_opcode", OCF_opcode_out, last_op);
        end
    end

    // Entered while the DUT is in IDLE or T4; returns #1 after entering T4.
    task automatic fetch(input logic [15:0] pc, input logic [7:0] op, input int waits);
        exp_t e;
        e.pc = pc; e.op = op; e.waits = waits;
        sb.push_back(e);
        PC = pc;
        OCF_start = 1'b1;
        @(posedge clk); #1;                     // T1
        OCF_start = 1'($urandom);
        PC = 16'h1234;
        OCF_data_in = 8'($urandom);
        @(posedge clk); #1;                     // T2
        OCF_start = 1'($urandom);
        PC = 16'($urandom);
        for (int i = 0; i < waits; i++) begin
            WAIT_L = 1'b0;
            OCF_data_in = 8'($urandom);
            @(posedge clk); #1;                 // TW
        end
        WAIT_L = 1'b1;
        OCF_data_in = op;
        OCF_start = 1'($urandom);
        INT_L = 1'($urandom);
        NMI_L = 1'($urandom);
        @(posedge clk); #1;                     // T3
        OCF_data_in = 8'($urandom);
        OCF_start = 1'($urandom);
        @(posedge clk); #1;                     // T4
        OCF_start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        check(nm, {OCF_M1_L, OCF_MREQ_L, OCF_RD_L, OCF_RFSH_L, OCF_done, OCF_opcode_valid,
                   OCF_opcode_out, OCF_addr_out}, {6'b111100, 8'h00, 16'h0000});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_values");
        rst_L = 1'b1;
        @(posedge clk); #1;

        // Directed single fetch, then a two-wait fetch.
        fetch(16'hBEEF, 8'h3C, 0);
        @(posedge clk); #1;
        fetch(16'($urandom), 8'($urandom), 2);
        @(posedge clk); #1;

        // Start held: back-to-back fetches with no IDLE in between.
        for (int i = 0; i < 6; i++) fetch(16'($urandom), 8'($urandom), 0);

        // Random mix, long enough to wrap the refresh counter.
        for (int i = 0; i < 140; i++) begin
            fetch(16'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                end
            end
        end
        @(posedge clk); #1;

        // Reset asserted while in TW discards the fetch.
        sb.push_back('{16'hCAFE, 8'h55, 5});
        PC = 16'hCAFE;
        OCF_start = 1'b1;
        @(posedge clk); #1;
        OCF_start = 1'b0;
        @(posedge clk); #1;
        WAIT_L = 1'b0;
        @(posedge clk); #1;
        rst_L = 1'b0;
        #1;
        check_reset_outputs("reset_in_tw");
        @(posedge clk); #1;
        rst_L = 1'b1;
        WAIT_L = 1'b1;
        @(posedge clk); #1;

        // Refresh counter restarts from zero after reset.
        for (int i = 0; i < 3; i++) fetch(16'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("scoreboard_drained", sb.size(), 0);
        check("fetches_after_reset", done_cnt, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
